mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle unsigned 32x32 multiplier controller for the single-cycle MIPS core; executes multu and owns the architectural HI/LO registers.
- Triggered by the decoder's domul. Serves mfhi/mflo reads, selected by multoreg and lohi.
- Raises stall so the core freezes PC and instruction while a multiply is in flight and a dependent or new mul instruction arrives.
- Radix-2 shift-add: one partial product per cycle.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- domul  in  1  decoded multu in the current instruction
- multoreg  in  1  decoded mfhi/mflo in the current instruction
- lohi  in  1  read select for multoreg: 0 = LO, 1 = HI
- srca  in  WIDTH  rs operand (multiplicand)
- srcb  in  WIDTH  rt operand (multiplier)
- stall  out  1  core must hold PC and instruction this cycle
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse when HI/LO are updated
- mulresult  out  WIDTH  lohi ? HI : LO (combinational from the architectural registers)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; HI, LO, accumulator and counter are cleared to 0.
  - busy=0, done=0, stall=0, mulresult=0.
  - Reset asserted mid-multiply aborts the operation; HI/LO read 0 afterwards.
- States: IDLE, RUN.
- IDLE:
  - If domul=1: capture srca into the multiplicand register M.
  - Load product P[2W-1:0] = {W'b0, srcb}. Set count=0 and go to RUN.
  - stall=0, so the core retires multu in this single cycle.
  - If multoreg=1: mulresult is valid this cycle with no stall.
- RUN, each cycle:
  - sum[W:0] = P[2W-1:W] + (P[0] ? M : 0).
  - P <= {sum, P[W-1:1]}; count <= count+1.
  - sum keeps the carry bit; no overflow is possible.
- Final RUN cycle (count==WIDTH-1):
  - The last step is computed.
  - {HI,LO} <= the final P (= srca*srcb unsigned) at that edge.
  - done=1 for the cycle after the edge; state goes to IDLE.
- Latency:
  - Issue cycle, then WIDTH RUN cycles.
  - HI/LO are valid from issue+WIDTH+1.
  - A multu followed by independent instructions does not stall.
- busy = (state==RUN).
- stall = busy & (domul | multoreg).
  - In RUN, a new multu is not captured. The core holds it; it is accepted in the first IDLE cycle.
  - A read during RUN stalls until IDLE, then sees the new HI/LO (no stale read).
- HI/LO change only at completion. Architectural values stay stable during RUN.
- domul and multoreg asserted together: illegal encoding, but defined: domul has priority and mulresult shows the pre-multiply HI/LO.
- X on lohi with multoreg=0 is don't-care. mulresult is still driven from HI/LO with no X propagation requirement.

Decomposition:
- Package mul_pkg holds:
  - state enum {IDLE, RUN} (1 bit);
  - localparams for the MIPS funct codes MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010;
  - CNT_W.
- One natural sub-module, mul_shift_add_step: combinational single iteration, (P, M) -> next P. The FSM, counter, HI/LO and stall logic stay in mul_sequencer.

Test Plan:
- Reset mid-RUN: multu 7*6, assert reset at RUN cycle 10 -> busy=0, HI=LO=0, done never pulses; a later mflo returns 0.
- Basic: multu srca=7, srcb=6; mflo issued 40 cycles later -> done pulses exactly once, 33 cycles after issue; mflo returns 42, mfhi returns 0, no stall seen.
- Full width: srca=srcb=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. Also srca=32'h80000000, srcb=2 -> HI=1, LO=0.
- Early read: multu 3*5, then mfhi in the next cycle -> stall=1 for 32 cycles; when it releases, mulresult=0 with lohi=1; a mflo afterwards returns 15.
- Back-to-back: multu 2*3 then multu 4*5 in the next cycle -> the second stalls until IDLE, is then accepted; final LO=20; done pulses twice.
- Zero and priority:
  - srcb=0 -> LO=HI=0 after the full latency.
  - domul and multoreg both high in IDLE -> multiply starts; mulresult shows the old LO.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the multu / mfhi / mflo sequencer.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    localparam int CNT_W = 6;

endpackage

// File: rtl/mul_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add M into the upper half,
// then shift the whole product right by one, keeping the carry.
module mul_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0]   i_m,
    output logic [2*WIDTH-1:0] o_p_next
);

    logic [WIDTH:0] w_addend;
    logic [WIDTH:0] w_sum;

    assign w_addend = i_p[0] ? {1'b0, i_m} : '0;
    assign w_sum    = {1'b0, i_p[2*WIDTH-1:WIDTH]} + w_addend;
    assign o_p_next = {w_sum, i_p[WIDTH-1:1]};

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned multiplier owning the architectural HI/LO registers.
// A multu retires in its issue cycle; the core stalls only on a dependent read or a new multu.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = mul_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             domul,
    input  logic             multoreg,
    input  logic             lohi,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mulresult
);

    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
        $error("CNT_W too narrow for WIDTH iterations");
    end
    if ((MULTU == MFHI) || (MULTU == MFLO) || (MFHI == MFLO)) begin : g_bad_funct
        $error("funct codes must be distinct");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] w_p_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                // domul wins over multoreg; the read still sees the old HI/LO.
                if (domul) begin
                    w_start      = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    mul_shift_add_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_p     (r_p),
        .i_m     (r_m),
        .o_p_next(w_p_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_start) begin
                r_m   <= srca;
                r_p   <= {{WIDTH{1'b0}}, srcb};
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_p   <= w_p_next;
                r_cnt <= r_cnt + CNT_W'(1);
                // HI/LO only move at completion so reads during RUN never see partials.
                if (w_last) begin
                    {r_hi, r_lo} <= w_p_next;
                end
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign stall     = busy & (domul | multoreg);
    assign done      = r_done;
    assign mulresult = lohi ? r_hi : r_lo;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: expected products are queued at issue
// and popped when HI/LO are read back through mfhi/mflo.
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         domul;
    logic         multoreg;
    logic         lohi;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] mulresult;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q[$];

    mul_sequencer #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .domul    (domul),
        .multoreg (multoreg),
        .lohi     (lohi),
        .srca     (srca),
        .srcb     (srcb),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .mulresult(mulresult)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        domul    = 1'b0;
        multoreg = 1'b0;
        lohi     = 1'b0;
        srca     = '0;
        srcb     = '0;
    endtask

    task automatic issue_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        @(negedge clk);
        idle_inputs();
        domul = 1'b1;
        srca  = a;
        srcb  = b;
        exp_q.push_back(wa * wb);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL issue_stall: stall=%b required 0", stall);
        end
    endtask

    task automatic wait_done(input int budget, output int first_lat, output int pulses);
        first_lat = -1;
        pulses    = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (first_lat < 0) first_lat = i;
            end
        end
    endtask

    task automatic read_reg(input logic hi, output logic [W-1:0] val, output logic st);
        @(negedge clk);
        idle_inputs();
        multoreg = 1'b1;
        lohi     = hi;
        #1;
        val = mulresult;
        st  = stall;
    endtask

    task automatic check_product(input string name);
        logic [2*W-1:0] e;
        logic [W-1:0]   v;
        logic           st;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_scoreboard: queue empty, required one pending product", name);
            return;
        end
        e = exp_q.pop_front();
        read_reg(1'b0, v, st);
        n_cmp++;
        if (v !== e[W-1:0] || st !== 1'b0) begin
            n_err++;
            $display("FAIL %s_lo: got %h stall=%b required %h stall=0", name, v, st, e[W-1:0]);
        end
        read_reg(1'b1, v, st);
        n_cmp++;
        if (v !== e[2*W-1:W] || st !== 1'b0) begin
            n_err++;
            $display("FAIL %s_hi: got %h stall=%b required %h stall=0", name, v, st, e[2*W-1:W]);
        end
    endtask

    task automatic run_product(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int pulses;
        issue_mul(a, b);
        wait_done(40, lat, pulses);
        n_cmp++;
        if (lat !== W + 1 || pulses !== 1) begin
            n_err++;
            $display("FAIL %s_done: latency=%0d pulses=%0d required latency=%0d pulses=1",
                     name, lat, pulses, W + 1);
        end
        check_product(name);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        domul    = 1'b1;
        multoreg = 1'b1;
        lohi     = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || mulresult !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b stall=%b lo=%h required 0/0/0/0",
                     busy, done, stall, mulresult);
        end
        lohi = 1'b1;
        #1;
        n_cmp++;
        if (mulresult !== '0) begin
            n_err++;
            $display("FAIL reset_hi: got %h required 0", mulresult);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        int pulses;
        issue_mul(32'd7, 32'd6);
        wait_done(40, lat, pulses);
        n_cmp++;
        if (lat !== 33 || pulses !== 1) begin
            n_err++;
            $display("FAIL basic_done: latency=%0d pulses=%0d required 33/1", lat, pulses);
        end
        check_product("basic");
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int pulses;
        logic [W-1:0] v;
        logic st;
        issue_mul(32'd7, 32'd6);
        repeat (9) begin
            @(negedge clk);
            idle_inputs();
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || mulresult !== '0) begin
            n_err++;
            $display("FAIL midrst_state: busy=%b done=%b lo=%h required 0/0/0", busy, done, mulresult);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        wait_done(40, lat, pulses);
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL midrst_done: pulses=%0d required 0", pulses);
        end
        read_reg(1'b0, v, st);
        n_cmp++;
        if (v !== '0 || st !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_lo: got %h stall=%b required 0 stall=0", v, st);
        end
        read_reg(1'b1, v, st);
        n_cmp++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL midrst_hi: got %h required 0", v);
        end
    endtask

    task automatic test_full_width();
        run_product("full_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_product("msb_x2", 32'h8000_0000, 32'd2);
        for (int i = 0; i < 3; i++) begin
            run_product("random", W'($urandom), W'($urandom_range(1, 32'hFFFF_FFFF)));
        end
    endtask

    task automatic test_early_read();
        int stall_cnt;
        logic [W-1:0] rel;
        logic rel_done;
        logic released;
        logic [2*W-1:0] e;
        logic [W-1:0] v;
        logic st;
        stall_cnt = 0;
        rel       = '0;
        rel_done  = 1'b0;
        released  = 1'b0;
        issue_mul(32'd3, 32'd5);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            idle_inputs();
            multoreg = 1'b1;
            lohi     = 1'b1;
            #1;
            if (stall === 1'b1) begin
                stall_cnt++;
            end else begin
                rel      = mulresult;
                rel_done = done;
                released = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (stall_cnt !== W || released !== 1'b1 || rel_done !== 1'b1) begin
            n_err++;
            $display("FAIL early_stall: stalls=%0d released=%b done=%b required %0d/1/1",
                     stall_cnt, released, rel_done, W);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rel !== e[2*W-1:W]) begin
            n_err++;
            $display("FAIL early_hi: got %h required %h", rel, e[2*W-1:W]);
        end
        read_reg(1'b0, v, st);
        n_cmp++;
        if (v !== e[W-1:0] || st !== 1'b0) begin
            n_err++;
            $display("FAIL early_lo: got %h stall=%b required %h stall=0", v, st, e[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int stall_cnt;
        int pulses;
        int lat;
        int p2;
        logic [W-1:0] rel_lo;
        logic [2*W-1:0] e;
        stall_cnt = 0;
        pulses    = 0;
        rel_lo    = '0;
        issue_mul(32'd2, 32'd3);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            idle_inputs();
            domul = 1'b1;
            srca  = 32'd4;
            srcb  = 32'd5;
            #1;
            if (done === 1'b1) pulses++;
            if (stall === 1'b1) begin
                stall_cnt++;
            end else begin
                rel_lo = mulresult;
                break;
            end
        end
        exp_q.push_back(64'd20);
        n_cmp++;
        if (stall_cnt !== W) begin
            n_err++;
            $display("FAIL b2b_stall: stalls=%0d required %0d", stall_cnt, W);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rel_lo !== e[W-1:0]) begin
            n_err++;
            $display("FAIL b2b_first_lo: got %h required %h", rel_lo, e[W-1:0]);
        end
        wait_done(40, lat, p2);
        n_cmp++;
        if (lat !== W + 1 || pulses + p2 !== 2) begin
            n_err++;
            $display("FAIL b2b_done: latency=%0d pulses=%0d required %0d/2", lat, pulses + p2, W + 1);
        end
        check_product("b2b");
    endtask

    task automatic test_zero_priority();
        int lat;
        int pulses;
        logic [W-1:0] old_lo;
        run_product("zero_b", W'($urandom), 32'd0);
        issue_mul(32'd9, 32'd9);
        wait_done(40, lat, pulses);
        old_lo = exp_q[0][W-1:0];
        check_product("pre_prio");
        @(negedge clk);
        idle_inputs();
        domul    = 1'b1;
        multoreg = 1'b1;
        lohi     = 1'b0;
        srca     = 32'd10;
        srcb     = 32'd11;
        exp_q.push_back(64'd110);
        #1;
        n_cmp++;
        if (stall !== 1'b0 || mulresult !== old_lo) begin
            n_err++;
            $display("FAIL prio_read: stall=%b lo=%h required 0/%h", stall, mulresult, old_lo);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL prio_busy: busy=%b required 1", busy);
        end
        wait_done(40, lat, pulses);
        n_cmp++;
        if (lat !== W || pulses !== 1) begin
            n_err++;
            $display("FAIL prio_done: latency=%0d pulses=%0d required %0d/1", lat, pulses, W);
        end
        check_product("prio");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_full_width();
        test_early_read();
        test_back_to_back();
        test_zero_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
